// File: rtl/systolic_feeder.sv
// Operand feeder for a 2x2 systolic array: buffers A (2xK) and B (Kx2), then
// streams them diagonally skewed by one cycle and drives zeros when idle.
module systolic_feeder #(
  parameter int datawith = 16,
  parameter int k_max    = 8,
  parameter int kw       = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                wr_sel,
  input  logic                wr_lane,
  input  logic [kw-1:0]       wr_addr,
  input  logic [datawith-1:0] wr_data,
  output logic                wr_err,
  input  logic                start,
  input  logic [kw:0]         k_len,
  output logic                busy,
  output logic                done,
  output logic                systolic_en,
  output logic [datawith-1:0] data_1,
  output logic [datawith-1:0] data_2,
  output logic [datawith-1:0] weight_1,
  output logic [datawith-1:0] weight_2
);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, FINISH} state_t;

  state_t              state_reg;
  logic [kw:0]         t_reg;
  logic [kw:0]         k_reg;
  logic [kw:0]         t_next;
  logic [kw:0]         t_prev;
  logic [kw:0]         k_eff;
  logic                wr_ok;
  logic [datawith-1:0] a_rd [2];
  logic [datawith-1:0] b_rd [2];

  assign wr_ok  = wr_en & ~busy;
  assign t_next = (state_reg == IDLE) ? '0 : t_reg + (kw+1)'(1);
  assign t_prev = t_next - (kw+1)'(1);
  assign k_eff  = (k_len > (kw+1)'(k_max)) ? (kw+1)'(k_max) : k_len;

  // Lane 0 reads the current index, lane 1 the previous one (diagonal skew).
  // A write in the start cycle is forwarded so the stream sees the new value.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [datawith-1:0] a_mem [k_max];
    logic [datawith-1:0] b_mem [k_max];
    logic [kw:0]         idx_full;
    logic [kw-1:0]       idx;
    logic                a_hit;
    logic                b_hit;

    assign idx_full = (gi == 0) ? t_next : t_prev;
    assign idx      = idx_full[kw-1:0];
    assign a_hit    = wr_ok && !wr_sel && (wr_lane == 1'(gi)) && (wr_addr == idx);
    assign b_hit    = wr_ok &&  wr_sel && (wr_lane == 1'(gi)) && (wr_addr == idx);
    assign a_rd[gi] = a_hit ? wr_data : a_mem[idx];
    assign b_rd[gi] = b_hit ? wr_data : b_mem[idx];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < k_max; i++) begin
          a_mem[i] <= '0;
          b_mem[i] <= '0;
        end
      end else if (wr_ok && (wr_lane == 1'(gi))) begin
        if (wr_sel) b_mem[wr_addr] <= wr_data;
        else        a_mem[wr_addr] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      t_reg       <= '0;
      k_reg       <= '0;
      wr_err      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      systolic_en <= 1'b0;
      data_1      <= '0;
      data_2      <= '0;
      weight_1    <= '0;
      weight_2    <= '0;
    end else begin
      wr_err <= wr_en & busy;
      case (state_reg)
        IDLE: begin
          if (start) begin
            k_reg <= k_eff;
            busy  <= 1'b1;
            t_reg <= '0;
            if (k_eff == '0) begin
              state_reg <= FINISH;
              done      <= 1'b1;
            end else begin
              state_reg   <= FEED;
              systolic_en <= 1'b1;
              data_1      <= a_rd[0];
              weight_1    <= b_rd[0];
              data_2      <= '0;
              weight_2    <= '0;
            end
          end
        end
        FEED: begin
          if (t_reg == k_reg) begin
            state_reg <= DRAIN;
            t_reg     <= '0;
            data_1    <= '0;
            data_2    <= '0;
            weight_1  <= '0;
            weight_2  <= '0;
          end else begin
            t_reg    <= t_next;
            data_1   <= (t_next < k_reg) ? a_rd[0] : '0;
            weight_1 <= (t_next < k_reg) ? b_rd[0] : '0;
            data_2   <= a_rd[1];
            weight_2 <= b_rd[1];
          end
        end
        DRAIN: begin
          if (t_reg == (kw+1)'(1)) begin
            state_reg   <= FINISH;
            t_reg       <= '0;
            systolic_en <= 1'b0;
            done        <= 1'b1;
          end else begin
            t_reg <= t_reg + (kw+1)'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: stimulus pushes expected stream beats,
// a negedge monitor pops and compares whenever systolic_en or done is high.
module tb_systolic_feeder;
  localparam int DW = 16;
  localparam int KM = 8;
  localparam int KW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0, wr_sel = 1'b0, wr_lane = 1'b0;
  logic [KW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_err;
  logic          start = 1'b0;
  logic [KW:0]   k_len = '0;
  logic          busy, done, systolic_en;
  logic [DW-1:0] data_1, data_2, weight_1, weight_2;

  systolic_feeder #(.datawith(DW), .k_max(KM), .kw(KW)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_lane(wr_lane), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_err(wr_err),
    .start(start), .k_len(k_len),
    .busy(busy), .done(done), .systolic_en(systolic_en),
    .data_1(data_1), .data_2(data_2), .weight_1(weight_1), .weight_2(weight_2)
  );

  always #5 clk = ~clk;

  typedef logic [65:0] beat_t;   // {systolic_en, done, d1, d2, w1, w2}

  int      n_vec = 0;
  int      n_miss = 0;
  beat_t   exp_q[$];
  logic [DW-1:0] ma [2][KM];     // model of A buffer [row][k]
  logic [DW-1:0] mb [2][KM];     // model of B buffer [col][k]
  longint  acc00 = 0;
  longint  acc11 = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic sen, input logic dn, input int d1, input int d2,
                               input int w1, input int w2);
    return {sen, dn, DW'(d1), DW'(d2), DW'(w1), DW'(w2)};
  endfunction

  task automatic push_run(input int k);
    for (int t = 0; k > 0 && t <= k; t++)
      exp_q.push_back(mk(1'b1, 1'b0,
        (t < k) ? int'(ma[0][t]) : 0,
        (t >= 1) ? int'(ma[1][t-1]) : 0,
        (t < k) ? int'(mb[0][t]) : 0,
        (t >= 1) ? int'(mb[1][t-1]) : 0));
    if (k > 0) begin
      exp_q.push_back(mk(1'b1, 1'b0, 0, 0, 0, 0));
      exp_q.push_back(mk(1'b1, 1'b0, 0, 0, 0, 0));
    end
    exp_q.push_back(mk(1'b0, 1'b1, 0, 0, 0, 0));
  endtask

  // Monitor: models the two diagonal PEs and checks every presented beat.
  always @(negedge clk) begin
    if (rst) begin
      acc00 += longint'(data_1) * longint'(weight_1);
      acc11 += longint'(data_2) * longint'(weight_2);
      if (systolic_en || done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 72'({systolic_en, done, data_1, data_2, weight_1, weight_2}), 72'(0));
        end else begin
          check("stream_beat", 72'({systolic_en, done, data_1, data_2, weight_1, weight_2}),
                72'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic wr(input logic sel, input logic lane, input int addr, input int val);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_sel = sel; wr_lane = lane; wr_addr = KW'(addr); wr_data = DW'(val);
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (sel) mb[lane][addr] = DW'(val);
    else     ma[lane][addr] = DW'(val);
  endtask

  task automatic load_t1();
    wr(0, 0, 0, 1); wr(0, 0, 1, 2); wr(0, 1, 0, 3); wr(0, 1, 1, 4);
    wr(1, 0, 0, 5); wr(1, 1, 0, 6); wr(1, 0, 1, 7); wr(1, 1, 1, 8);
  endtask

  // sw >= 0: write A[0][0]=sw in the same cycle as start.
  task automatic run(input int k_in, input int k_eff, input bit inj_wr, input bit inj_start,
                     input int sw, input string tag);
    int c;
    @(posedge clk); #1;
    start = 1'b1; k_len = (KW+1)'(k_in);
    if (sw >= 0) begin
      wr_en = 1'b1; wr_sel = 1'b0; wr_lane = 1'b0; wr_addr = '0; wr_data = DW'(sw);
    end
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    check({tag, "_busy"}, 72'(busy), 72'(1));
    c = 0;
    while (!done && c < 40) begin
      if (inj_wr) begin
        if (c == 0) begin
          wr_en = 1'b1; wr_sel = 1'b0; wr_lane = 1'b0; wr_addr = '0; wr_data = 16'd999;
        end
        if (c == 1) begin
          wr_en = 1'b0;
          check({tag, "_wr_err_pulse"}, 72'(wr_err), 72'(1));
        end
        if (c == 2) check({tag, "_wr_err_clear"}, 72'(wr_err), 72'(0));
      end
      if (inj_start) begin
        if (c == k_eff + 1) start = 1'b1;
        if (c == k_eff + 2) start = 1'b0;
      end
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0; wr_en = 1'b0;
    check({tag, "_latency"}, 72'(c), 72'((k_eff == 0) ? 0 : k_eff + 3));
    @(posedge clk); #1;
    check({tag, "_idle_after"}, 72'({busy, done, systolic_en}), 72'(0));
    check({tag, "_queue_drained"}, 72'(exp_q.size()), 72'(0));
  endtask

  initial begin
    longint s0, s1;
    for (int l = 0; l < 2; l++)
      for (int i = 0; i < KM; i++) begin ma[l][i] = '0; mb[l][i] = '0; end

    #12;
    check("reset_outputs", 72'({busy, done, systolic_en, wr_err, data_1, data_2, weight_1, weight_2}), 72'(0));
    @(negedge clk); rst = 1'b1;

    // Skew and values, hand-computed beats.
    load_t1();
    exp_q.push_back(mk(1, 0, 1, 0, 5, 0));
    exp_q.push_back(mk(1, 0, 2, 3, 7, 6));
    exp_q.push_back(mk(1, 0, 0, 4, 0, 8));
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(0, 1, 0, 0, 0, 0));
    s0 = acc00; s1 = acc11;
    run(2, 2, 0, 0, -1, "t1");
    check("t1_c00", 72'(acc00 - s0), 72'(19));
    check("t1_c11", 72'(acc11 - s1), 72'(50));

    // Write coinciding with start is used by the stream.
    ma[0][0] = 16'd9;
    push_run(2);
    run(2, 2, 0, 0, 9, "wr_with_start");
    wr(0, 0, 0, 1);

    // Writes and start while busy are ignored.
    push_run(2);
    run(2, 2, 1, 1, -1, "busy_prot");

    // Zero length: immediate done, nothing streamed.
    push_run(0);
    run(0, 0, 0, 0, -1, "k0");

    // Reset at FEED t=1; buffer still holds A[0][0]=1 from before.
    exp_q.push_back(mk(1, 0, 1, 0, 5, 0));
    @(posedge clk); #1; start = 1'b1; k_len = 3'd2;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    #1;
    check("midreset_outputs", 72'({busy, done, systolic_en, data_1, data_2, weight_1, weight_2}), 72'(0));
    check("midreset_queue", 72'(exp_q.size()), 72'(0));
    repeat (2) @(posedge clk);
    #2; rst = 1'b1;
    repeat (4) @(posedge clk);
    for (int l = 0; l < 2; l++)
      for (int i = 0; i < KM; i++) begin ma[l][i] = '0; mb[l][i] = '0; end
    push_run(2);
    run(2, 2, 0, 0, -1, "cleared_bufs");
    load_t1();
    push_run(2);
    s0 = acc00; s1 = acc11;
    run(2, 2, 0, 0, -1, "rerun_t1");
    check("rerun_c00", 72'(acc00 - s0), 72'(19));
    check("rerun_c11", 72'(acc11 - s1), 72'(50));

    // Full depth.
    for (int i = 0; i < KM; i++) begin
      wr(0, 0, i, i + 1);
      wr(1, 0, i, i + 1);
    end
    push_run(8);
    s0 = acc00;
    run(8, 8, 0, 0, -1, "full");
    check("full_c00", 72'(acc00 - s0), 72'(204));

    // Oversized length is clamped.
    push_run(8);
    run(12, 8, 0, 0, -1, "clamp");

    repeat (3) @(posedge clk);
    #1;
    check("final_queue", 72'(exp_q.size()), 72'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
